// File: rtl/pokey_audio_pkg.sv
// Shared constants for the POKEY audio output path: PCM format, I2S framing and clamp limit.
package pokey_audio_pkg;
    localparam int          AUD_MID    = 30;
    localparam int          SAMPLE_W   = 16;
    localparam int          SLOT_BITS  = 32;
    localparam int          FRAME_BITS = 64;
    localparam logic [15:0] CLAMP_MAX  = 16'h7FFF;
endpackage

// File: rtl/audio_window_acc.sv
// Box-car sum of 6-bit audio over a gated window, converted to DC-centred 16-bit PCM.
// Latency: sample registers on the latch edge using the sum including that cycle's audio.
// Backpressure: none; free-running, sample holds until the next latch.
module audio_window_acc
    import pokey_audio_pkg::*;
#(
    parameter int ACC_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          audio,
    input  logic                mute,
    input  logic                win_en,
    input  logic                win_clr,
    input  logic                latch,
    output logic [SAMPLE_W-1:0] sample
);
    localparam int ACC_W      = ACC_LOG2 + 6;
    localparam int MID_SCALED = AUD_MID << ACC_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_sum;
    logic signed [17:0]  w_diff;
    logic signed [17:0]  w_v;
    logic [SAMPLE_W-1:0] w_pcm;
    logic [SAMPLE_W-1:0] r_sample;

    // First window cycle restarts the sum rather than adding to stale state.
    assign w_sum  = win_clr ? ACC_W'(audio) : r_acc + ACC_W'(audio);
    assign w_diff = $signed(18'(w_sum)) - $signed(18'(MID_SCALED));
    assign w_v    = w_diff <<< (10 - ACC_LOG2);
    assign w_pcm  = (w_v > $signed({2'b00, CLAMP_MAX})) ? CLAMP_MAX : w_v[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_sample <= '0;
        end else begin
            if (win_en) begin
                r_acc <= w_sum;
            end
            if (latch) begin
                r_sample <= mute ? '0 : w_pcm;
            end
        end
    end

    assign sample = r_sample;
endmodule

// File: rtl/pokey_i2s_out.sv
// Mono 16-bit I2S transmitter for averaged POKEY audio; all outputs registered from next-state fc.
// Latency: new sample at fc=0 of each frame, MSB on i2s_sdata at fc=2*BCLK_HALF.
// Backpressure: none; the codec is a pure slave of i2s_bclk/i2s_lrclk.
module pokey_i2s_out
    import pokey_audio_pkg::*;
#(
    parameter int BCLK_HALF = 10,
    parameter int ACC_LOG2  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          audio,
    input  logic                mute,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_stb
);
    localparam int FRAME_CLKS = 2 * FRAME_BITS * BCLK_HALF;
    localparam int WIN_START  = FRAME_CLKS - (1 << ACC_LOG2);
    localparam int FC_W       = $clog2(FRAME_CLKS);
    localparam int SUB_W      = $clog2(BCLK_HALF);
    localparam int H_W        = $clog2(2 * FRAME_BITS);
    localparam int B_W        = H_W - 1;
    localparam int J_W        = $clog2(SLOT_BITS);
    localparam int SEL_W      = $clog2(SAMPLE_W);

    logic [FC_W-1:0]  r_fc;
    logic [SUB_W-1:0] r_sub;
    logic [H_W-1:0]   r_h;
    logic             r_bclk;
    logic             r_lrclk;
    logic             r_sdata;
    logic             r_stb;

    logic             w_fc_last;
    logic             w_sub_last;
    logic [FC_W-1:0]  w_fc_nxt;
    logic [SUB_W-1:0] w_sub_nxt;
    logic [H_W-1:0]   w_h_nxt;
    logic [B_W-1:0]   w_b_nxt;
    logic [J_W-1:0]   w_j;
    logic [SEL_W-1:0] w_bitsel;
    logic             w_lrclk_nxt;
    logic             w_sdata_nxt;
    logic             w_win_en;
    logic             w_win_clr;

    assign w_fc_last  = (r_fc == FC_W'(FRAME_CLKS - 1));
    assign w_sub_last = (r_sub == SUB_W'(BCLK_HALF - 1));
    assign w_fc_nxt   = w_fc_last ? '0 : r_fc + 1'b1;
    assign w_sub_nxt  = w_sub_last ? '0 : r_sub + 1'b1;
    // The half-period index wraps with fc because FRAME_CLKS is exactly 128 half-periods.
    assign w_h_nxt    = w_sub_last ? r_h + 1'b1 : r_h;

    assign w_b_nxt     = w_h_nxt[H_W-1:1];
    assign w_j         = w_b_nxt[J_W-1:0];
    assign w_bitsel    = SEL_W'(J_W'(SAMPLE_W) - w_j);
    assign w_lrclk_nxt = (w_b_nxt >= B_W'(SLOT_BITS));
    // sample only changes entering fc=0, where j=0 forces padding, so the current value is safe.
    assign w_sdata_nxt = (w_j != '0) && (w_j <= J_W'(SAMPLE_W)) ? sample[w_bitsel] : 1'b0;

    assign w_win_en  = (r_fc >= FC_W'(WIN_START));
    assign w_win_clr = (r_fc == FC_W'(WIN_START));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fc    <= '0;
            r_sub   <= '0;
            r_h     <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_fc    <= w_fc_nxt;
            r_sub   <= w_sub_nxt;
            r_h     <= w_h_nxt;
            r_bclk  <= w_h_nxt[0];
            r_lrclk <= w_lrclk_nxt;
            r_sdata <= w_sdata_nxt;
            r_stb   <= w_fc_last;
        end
    end

    audio_window_acc #(
        .ACC_LOG2 (ACC_LOG2)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .audio   (audio),
        .mute    (mute),
        .win_en  (w_win_en),
        .win_clr (w_win_clr),
        .latch   (w_fc_last),
        .sample  (sample)
    );

    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_sdata  = r_sdata;
    assign sample_stb = r_stb;
endmodule

// File: tb/tb_pokey_i2s_out.sv
// Scoreboard bench: frame stimulus queues expected PCM words, a negedge monitor checks strobe,
// sample, serial slots and clock alignment against them.
module tb_pokey_i2s_out;
    localparam int FRAME     = 1280;
    localparam int WIN_START = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  audio = '0;
    logic        mute = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [15:0] sample;
    logic        sample_stb;

    pokey_i2s_out #(
        .BCLK_HALF (10),
        .ACC_LOG2  (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .audio      (audio),
        .mute       (mute),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata),
        .sample     (sample),
        .sample_stb (sample_stb)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic        done = 1'b0;
    logic        done_chk = 1'b0;

    // Cycles since reset release; equals the frame position modulo FRAME.
    int   cnt = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h cnt=%0d t=%0t", nm, act, exp, cnt, $time);
        end
    endtask

    logic [15:0] exp_cur = '0;
    logic [15:0] prev_sample = '0;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b0;
    logic        prev_sd = 1'b0;
    logic [31:0] word = '0;
    int          nbits = 0;
    int          last_rise = 0;
    logic        rise_valid = 1'b0;
    int          last_lr = 0;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_bclk", i2s_bclk, 0);
            chk("rst_lrclk", i2s_lrclk, 0);
            chk("rst_sdata", i2s_sdata, 0);
            chk("rst_sample", sample, 0);
            chk("rst_stb", sample_stb, 0);
            exp_cur     = '0;
            prev_sample = '0;
            prev_bclk   = 1'b0;
            prev_lr     = 1'b0;
            prev_sd     = 1'b0;
            word        = '0;
            nbits       = 0;
            rise_valid  = 1'b0;
            last_lr     = 0;
        end else begin
            if (cnt != 0 && cnt % FRAME == 0) begin
                chk("stb_present", sample_stb, 1);
                if (sample_stb) begin
                    if (exp_q.size() == 0) begin
                        chk("stb_has_expect", 0, 1);
                    end else begin
                        exp_cur = exp_q.pop_front();
                        chk("sample", sample, exp_cur);
                    end
                end
            end else if (sample_stb) begin
                chk("stb_unexpected", 1, 0);
            end
            if (sample !== prev_sample) chk("sample_chg_at_stb", sample_stb, 1);
            if (i2s_sdata !== prev_sd || i2s_lrclk !== prev_lr)
                chk("edge_align", {prev_bclk, i2s_bclk}, 2'b10);
            if (i2s_lrclk !== prev_lr) begin
                chk("lrclk_phase", cnt % 640, 0);
                chk("lrclk_half", cnt - last_lr, 640);
                last_lr = cnt;
            end
            if (i2s_bclk && !prev_bclk) begin
                chk("bclk_phase", cnt % 20, 10);
                if (rise_valid) chk("bclk_period", cnt - last_rise, 20);
                last_rise  = cnt;
                rise_valid = 1'b1;
                word  = {word[30:0], i2s_sdata};
                nbits = nbits + 1;
                if (nbits == 32) begin
                    chk("slot_word", word, {1'b0, exp_cur, 15'b0});
                    chk("slot_lr", i2s_lrclk, (cnt % FRAME) >= 640);
                    nbits = 0;
                end
            end
            prev_sample = sample;
            prev_bclk   = i2s_bclk;
            prev_lr     = i2s_lrclk;
            prev_sd     = i2s_sdata;
        end
        if (done && !done_chk) begin
            chk("queue_drained", exp_q.size(), 0);
            done_chk = 1'b1;
        end
    end

    task automatic frame(input logic [5:0] a_pre, input logic [5:0] a_win,
                         input logic m_other, input logic m_latch, input logic [15:0] exp);
        exp_q.push_back(exp);
        for (int i = 0; i < FRAME; i++) begin
            audio = (i < WIN_START) ? a_pre : a_win;
            mute  = (i == FRAME - 1) ? m_latch : m_other;
            @(negedge clk);
        end
    endtask

    // Sum = 60 (first window cycle) + 3 (last cycle); the 63 just before the window is excluded.
    task automatic edge_frame();
        exp_q.push_back(16'h883F);
        for (int i = 0; i < FRAME; i++) begin
            audio = (i == WIN_START - 1) ? 6'd63 :
                    (i == WIN_START)     ? 6'd60 :
                    (i == FRAME - 1)     ? 6'd3  : 6'd0;
            mute  = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        frame(6'd30, 6'd30, 1'b0, 1'b0, 16'h0000);
        frame(6'd30, 6'd30, 1'b0, 1'b0, 16'h0000);
        frame(6'd30, 6'd30, 1'b0, 1'b0, 16'h0000);
        frame(6'd60, 6'd60, 1'b0, 1'b0, 16'h7800);
        frame(6'd0,  6'd0,  1'b0, 1'b0, 16'h8800);
        frame(6'd63, 6'd63, 1'b0, 1'b0, 16'h7FFF);
        frame(6'd60, 6'd60, 1'b0, 1'b1, 16'h0000);
        frame(6'd60, 6'd60, 1'b0, 1'b0, 16'h7800);
        frame(6'd60, 6'd60, 1'b1, 1'b0, 16'h7800);
        frame(6'd45, 6'd45, 1'b0, 1'b0, 16'h3C00);
        frame(6'd63, 6'd0,  1'b0, 1'b0, 16'h8800);
        edge_frame();
        for (int i = 0; i < 700; i++) begin
            audio = 6'd60;
            mute  = 1'b0;
            @(negedge clk);
        end
        rst   = 1'b1;
        audio = 6'd0;
        @(negedge clk);
        rst = 1'b0;
        frame(6'd60, 6'd60, 1'b0, 1'b0, 16'h7800);
        frame(6'd0,  6'd0,  1'b0, 1'b0, 16'h8800);
        done = 1'b1;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
